// File: rtl/sdram_multiport_arbiter.sv
// sdram_multiport_arbiter: round-robin burst arbiter sharing one SDRAM controller among NCH write/read stream pairs
module sdram_multiport_arbiter #(
  parameter int NCH = 4,
  parameter int BL = 8,
  parameter int CW = 9,
  parameter int RW = 13,
  parameter int BW = 2,
  parameter int FW = 8,
  parameter int RD_THRESH = 128,
  localparam int AW = CW + RW + BW,
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NCH-1:0]  ch_en_i,
  input  logic [NCH-1:0]  ch_load_i,
  input  logic [NCH*AW-1:0] ch_wr_base_i,
  input  logic [NCH*AW-1:0] ch_wr_max_i,
  input  logic [NCH*AW-1:0] ch_rd_base_i,
  input  logic [NCH*AW-1:0] ch_rd_max_i,
  input  logic [NCH*FW-1:0] ch_wr_level_i,
  input  logic [NCH*FW-1:0] ch_rd_level_i,
  output logic            sd_wr_o,
  output logic            sd_rd_o,
  output logic [CW-1:0]   sd_caddr_o,
  output logic [RW-1:0]   sd_raddr_o,
  output logic [BW-1:0]   sd_baddr_o,
  input  logic            sd_ack_i,
  input  logic            sd_wdata_vaild_i,
  input  logic            sd_rdata_vaild_i,
  input  logic            sd_wdata_done_i,
  input  logic            sd_rdata_done_i,
  output logic [NCH-1:0]  ch_wr_vaild_o,
  output logic [NCH-1:0]  ch_rd_vaild_o,
  output logic [GW-1:0]   grant_ch_o,
  output logic            grant_dir_o,
  output logic            busy_o
);
  localparam int NS = 2 * NCH;
  localparam int SW = $clog2(NS);
  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;
  state_t state_q, state_d;
  logic sd_wr_q, sd_wr_d, sd_rd_q, sd_rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [GW-1:0] gch_q, gch_d, win_ch;
  logic gdir_q, gdir_d, win_dir, found, done;
  logic [SW-1:0] rr_q, rr_d, win;
  logic [NS-1:0] req;
  logic [AW-1:0] wr_ptr_q [NCH];
  logic [AW-1:0] wr_ptr_d [NCH];
  logic [AW-1:0] rd_ptr_q [NCH];
  logic [AW-1:0] rd_ptr_d [NCH];
  logic [AW-1:0] wr_base [NCH];
  logic [AW-1:0] wr_max [NCH];
  logic [AW-1:0] rd_base [NCH];
  logic [AW-1:0] rd_max [NCH];
  int idx;
  // one extra bit keeps ptr+BL from wrapping before the compare against max
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] p, input logic [AW-1:0] mx,
                                        input logic [AW-1:0] b);
    logic [AW:0] n;
    n = {1'b0, p} + (AW+1)'(BL);
    return (n >= {1'b0, mx}) ? b : n[AW-1:0];
  endfunction
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign wr_base[g] = ch_wr_base_i[g*AW +: AW];
    assign wr_max[g] = ch_wr_max_i[g*AW +: AW];
    assign rd_base[g] = ch_rd_base_i[g*AW +: AW];
    assign rd_max[g] = ch_rd_max_i[g*AW +: AW];
    assign req[2*g] = ch_en_i[g] & ~ch_load_i[g] & (32'(ch_wr_level_i[g*FW +: FW]) >= BL);
    assign req[2*g+1] = ch_en_i[g] & ~ch_load_i[g] & (32'(ch_rd_level_i[g*FW +: FW]) < RD_THRESH);
  end
  // slots interleave wr0, rd0, wr1, ...; search begins at rr_q
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NS; k++) begin
      idx = int'(rr_q) + k;
      idx = (idx >= NS) ? idx - NS : idx;
      if (!found && req[SW'(idx)]) begin
        found = 1'b1;
        win = SW'(idx);
      end
    end
  end
  assign win_ch = GW'(win >> 1);
  assign win_dir = ~win[0];
  assign done = gdir_q ? sd_wdata_done_i : sd_rdata_done_i;
  always_comb begin
    state_d = state_q;
    sd_wr_d = sd_wr_q;
    sd_rd_d = sd_rd_q;
    addr_d = addr_q;
    gch_d = gch_q;
    gdir_d = gdir_q;
    rr_d = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        gch_d = win_ch;
        gdir_d = win_dir;
        addr_d = win_dir ? wr_ptr_q[win_ch] : rd_ptr_q[win_ch];
        sd_wr_d = win_dir;
        sd_rd_d = ~win_dir;
        rr_d = (win == SW'(NS - 1)) ? '0 : win + 1'b1;
      end
      ISSUE: if (sd_ack_i) begin
        state_d = XFER;
        sd_wr_d = 1'b0;
        sd_rd_d = 1'b0;
      end
      XFER: if (done) begin
        state_d = IDLE;
        if (gdir_q) wr_ptr_d[gch_q] = adv(wr_ptr_q[gch_q], wr_max[gch_q], wr_base[gch_q]);
        else rd_ptr_d[gch_q] = adv(rd_ptr_q[gch_q], rd_max[gch_q], rd_base[gch_q]);
      end
      default: state_d = IDLE;
    endcase
    // a reload overrides any advance landing in the same cycle
    for (int i = 0; i < NCH; i++) begin
      wr_ptr_d[i] = ch_load_i[i] ? wr_base[i] : wr_ptr_d[i];
      rd_ptr_d[i] = ch_load_i[i] ? rd_base[i] : rd_ptr_d[i];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sd_wr_q <= 1'b0;
      sd_rd_q <= 1'b0;
      addr_q <= '0;
      gch_q <= '0;
      gdir_q <= 1'b0;
      rr_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= wr_base[i];
        rd_ptr_q[i] <= rd_base[i];
      end
    end else begin
      state_q <= state_d;
      sd_wr_q <= sd_wr_d;
      sd_rd_q <= sd_rd_d;
      addr_q <= addr_d;
      gch_q <= gch_d;
      gdir_q <= gdir_d;
      rr_q <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_comb begin
    ch_wr_vaild_o = '0;
    ch_rd_vaild_o = '0;
    if (state_q == XFER) begin
      if (gdir_q) ch_wr_vaild_o[gch_q] = sd_wdata_vaild_i;
      else ch_rd_vaild_o[gch_q] = sd_rdata_vaild_i;
    end
  end
  assign sd_wr_o = sd_wr_q;
  assign sd_rd_o = sd_rd_q;
  assign sd_caddr_o = addr_q[CW-1:0];
  assign sd_raddr_o = addr_q[CW+RW-1:CW];
  assign sd_baddr_o = addr_q[AW-1:CW+RW];
  assign grant_ch_o = gch_q;
  assign grant_dir_o = gdir_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_sdram_multiport_arbiter.sv
// tb_sdram_multiport_arbiter: directed and randomized checks against a burst-level reference model
module tb_sdram_multiport_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] en, load;
  logic [95:0] wb, wm, rb, rm;
  logic [31:0] wl, rl;
  logic ack, wv, rv, wd, rdn;
  logic sd_wr, sd_rd, gdir, busy;
  logic [8:0] ca;
  logic [12:0] ra;
  logic [1:0] ba, gch;
  logic [3:0] cwv, crv;
  int vec = 0, bad = 0;
  int m_phase, m_slot, m_next;
  logic [31:0] m_addr;
  logic [31:0] m_wp [4];
  logic [31:0] m_rp [4];
  logic [31:0] got [$];
  logic cmd_prev;
  logic [31:0] e;
  sdram_multiport_arbiter dut (
    .clk_i(clk), .rst_i(rst), .ch_en_i(en), .ch_load_i(load),
    .ch_wr_base_i(wb), .ch_wr_max_i(wm), .ch_rd_base_i(rb), .ch_rd_max_i(rm),
    .ch_wr_level_i(wl), .ch_rd_level_i(rl),
    .sd_wr_o(sd_wr), .sd_rd_o(sd_rd), .sd_caddr_o(ca), .sd_raddr_o(ra), .sd_baddr_o(ba),
    .sd_ack_i(ack), .sd_wdata_vaild_i(wv), .sd_rdata_vaild_i(rv),
    .sd_wdata_done_i(wd), .sd_rdata_done_i(rdn),
    .ch_wr_vaild_o(cwv), .ch_rd_vaild_o(crv), .grant_ch_o(gch), .grant_dir_o(gdir), .busy_o(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] fld(input logic [95:0] v, input int i);
    return {8'h0, v[i*24 +: 24]};
  endfunction
  function automatic int lvl(input logic [31:0] v, input int i);
    return int'(v[i*8 +: 8]);
  endfunction
  function automatic logic [31:0] step(input logic [31:0] p, input logic [31:0] mx, input logic [31:0] b);
    return (p + 8 >= mx) ? b : p + 8;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // burst-level model: idle -> command -> data, slot order and pointer wrap by plain arithmetic
  task automatic model_update();
    logic [31:0] nwp [4];
    logic [31:0] nrp [4];
    int s, c;
    bit r;
    if (rst) begin
      m_phase = 0;
      m_slot = 1;
      m_next = 0;
      m_addr = 0;
      for (int i = 0; i < 4; i++) begin
        m_wp[i] = fld(wb, i);
        m_rp[i] = fld(rb, i);
      end
    end else begin
      nwp = m_wp;
      nrp = m_rp;
      if (m_phase == 0) begin
        for (int k = 0; k < 8; k++) begin
          s = (m_next + k) % 8;
          c = s / 2;
          r = en[c] && !load[c] && ((s % 2 == 0) ? lvl(wl, c) >= 8 : lvl(rl, c) < 128);
          if (r) begin
            m_slot = s;
            m_phase = 1;
            m_addr = (s % 2 == 0) ? m_wp[c] : m_rp[c];
            m_next = (s + 1) % 8;
            break;
          end
        end
      end else if (m_phase == 1) begin
        if (ack) m_phase = 2;
      end else if ((m_slot % 2 == 0) ? wd : rdn) begin
        c = m_slot / 2;
        if (m_slot % 2 == 0) nwp[c] = step(m_wp[c], fld(wm, c), fld(wb, c));
        else nrp[c] = step(m_rp[c], fld(rm, c), fld(rb, c));
        m_phase = 0;
      end
      for (int i = 0; i < 4; i++) if (load[i]) begin
        nwp[i] = fld(wb, i);
        nrp[i] = fld(rb, i);
      end
      m_wp = nwp;
      m_rp = nrp;
    end
  endtask
  task automatic check();
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("sd_wr", 32'(sd_wr), 32'(m_phase == 1 && m_slot % 2 == 0));
    chk("sd_rd", 32'(sd_rd), 32'(m_phase == 1 && m_slot % 2 == 1));
    chk("grant_ch", 32'(gch), m_slot / 2);
    chk("grant_dir", 32'(gdir), 32'(m_slot % 2 == 0));
    chk("addr", {8'h0, ba, ra, ca}, m_addr);
    chk("wr_vaild", 32'(cwv), (m_phase == 2 && m_slot % 2 == 0 && wv) ? 32'd1 << (m_slot / 2) : 32'd0);
    chk("rd_vaild", 32'(crv), (m_phase == 2 && m_slot % 2 == 1 && rv) ? 32'd1 << (m_slot / 2) : 32'd0);
  endtask
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check();
  endtask
  task automatic drive_ctl(input int ackden);
    ack = (ackden == 0) ? 1'b0 : ($urandom_range(ackden - 1, 0) == 0);
    wv = 1'($urandom);
    rv = 1'($urandom);
    wd = ($urandom_range(3, 0) == 0);
    rdn = ($urandom_range(3, 0) == 0);
  endtask
  task automatic quiet();
    ack = 1'b0; wv = 1'b0; rv = 1'b0; wd = 1'b0; rdn = 1'b0;
  endtask
  task automatic do_reset();
    quiet();
    load = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic run_bursts(input int n, input int budget, input int ackden);
    got.delete();
    cmd_prev = sd_wr | sd_rd;
    for (int c = 0; c < budget && got.size() < n; c++) begin
      drive_ctl(ackden);
      tick();
      if ((sd_wr | sd_rd) && !cmd_prev) got.push_back({5'b0, gdir, gch, ba, ra, ca});
      cmd_prev = sd_wr | sd_rd;
    end
    chk("burst_count", got.size(), n);
  endtask
  task automatic steer_to_xfer();
    for (int c = 0; c < 20 && m_phase != 2; c++) begin
      quiet();
      ack = 1'b1;
      tick();
    end
    chk("reach_xfer", {30'b0, sd_wr | sd_rd, busy}, 32'b01);
  endtask
  initial begin
    en = 4'b0001; load = '0; wl = 32'h0000_0008; rl = 32'hC8C8_C8C8;
    wb = '0; wm = 96'd32; rb = '0; rm = '0;
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", {8'h0, ba, ra, ca}, 0);
    run_bursts(5, 400, 2);
    for (int k = 0; k < 5; k++) begin
      e = got[k];
      chk("single_caddr", e[23:0], (k * 8) % 32);
      chk("single_grant", e[26:24], 3'b100);
    end
    en = 4'hF; wl = 32'h0808_0808; rl = '0;
    wm = {4{24'h100000}}; rm = {4{24'h100000}};
    do_reset();
    run_bursts(9, 600, 2);
    for (int k = 0; k < 9; k++) begin
      e = got[k];
      chk("rr_slot", 32'(e[25:24]) * 2 + 32'(!e[26]), k % 8);
    end
    en = 4'b0001; wl = 32'h0000_0008; rl = 32'hC8C8_C8C8;
    wb = {72'h0, 24'h400A08}; wm = {72'h0, 24'hFFFFFF};
    do_reset();
    run_bursts(1, 100, 2);
    chk("split_bank", 32'(ba), 1);
    chk("split_row", 32'(ra), 5);
    chk("split_col", 32'(ca), 8);
    for (int c = 0; c < 10; c++) begin
      drive_ctl(0);
      tick();
      chk("stall_wr", 32'(sd_wr), 1);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_addr", {8'h0, ba, ra, ca}, 32'h400A08);
    end
    quiet();
    ack = 1'b1;
    tick();
    chk("ack_cmd_low", 32'(sd_wr), 0);
    en = 4'b0100; wl = 32'h0008_0000;
    wb = 96'h100 << 48; wm = 96'h1000 << 48;
    do_reset();
    steer_to_xfer();
    quiet();
    load = 4'b0100;
    wd = 1'b1;
    tick();
    load = '0;
    run_bursts(1, 50, 2);
    e = got[0];
    chk("load_wins", e[23:0], 24'h100);
    en = 4'b0010; wl = '0; rl = '0; wb = '0; wm = '0; rb = '0;
    do_reset();
    steer_to_xfer();
    for (int c = 0; c < 8; c++) begin
      quiet();
      wv = 1'b1;
      rv = (c % 2 == 0);
      tick();
      chk("route_rd", 32'(crv), rv ? 32'b0010 : 32'b0);
      chk("route_wr", 32'(cwv), 0);
    end
    rst = 1'b1;
    rv = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rd", 32'(crv), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cmd", 32'(sd_rd), 0);
    en = 4'hF;
    for (int i = 0; i < 4; i++) begin
      logic [23:0] b;
      b = 24'($urandom) & 24'h0FFFF8;
      wb[i*24 +: 24] = b;
      wm[i*24 +: 24] = b + 24'($urandom_range(40, 1));
      b = 24'($urandom) & 24'h0FFFF8;
      rb[i*24 +: 24] = b;
      rm[i*24 +: 24] = b + 24'($urandom_range(40, 1));
    end
    wb[72 +: 24] = 24'hFFFFE0;
    wm[72 +: 24] = 24'hFFFFFF;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3, 0) == 0) begin
        wl = $urandom;
        rl = $urandom;
      end
      if ($urandom_range(50, 0) == 0) en = 4'($urandom);
      load = ($urandom_range(30, 0) == 0) ? 4'($urandom) : 4'b0;
      rst = ($urandom_range(299, 0) == 0);
      drive_ctl(3);
      tick();
    end
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/sdram_multiport_arbiter.md
# sdram_multiport_arbiter

Parametrised front end that lets NCH independent streaming channels share one SDRAM controller. Each channel has a write stream and a read stream, giving 2·NCH request slots. Each slot has its own wrap-around burst address pointer, and a round-robin arbiter issues one burst command at a time to the controller. The block sits between the per-channel write/read FIFOs and the SDRAM controller. It routes the controller's data-valid strobes back to the granted channel's FIFO.

## Interface
- NCH, 4, number of channels (1..8)
- BL, 8, burst length in words; pointer step
- CW, 9, column address bits
- RW, 13, row address bits
- BW, 2, bank address bits; AW = CW+RW+BW (24 default)
- FW, 8, FIFO level width
- RD_THRESH, 128, read slot requests while read-FIFO level < RD_THRESH

- Clk  in  1  system clock; single clock domain
- Rst  in  1  synchronous, active-high reset
- Ch_en  in  NCH  channel enable
- Ch_load  in  NCH  per-channel pointer reload (both streams) to base
- Ch_wr_base / Ch_wr_max  in  NCH·AW  write start / end-exclusive address, packed ch0 in LSBs
- Ch_rd_base / Ch_rd_max  in  NCH·AW  read start / end-exclusive address
- Ch_wr_level  in  NCH·FW  write-FIFO readable word count
- Ch_rd_level  in  NCH·FW  read-FIFO written word count
- Sd_wr / Sd_rd  out  1  command request to controller (never both)
- Sd_caddr / Sd_raddr / Sd_baddr  out  CW / RW / BW  burst address
- Sd_ack  in  1  controller accepted command
- Sd_wdata_vaild / Sd_rdata_vaild  in  1  controller data-valid strobes
- Sd_wdata_done / Sd_rdata_done  in  1  single-cycle burst-complete pulses
- Ch_wr_vaild / Ch_rd_vaild  out  NCH  data-valid strobe gated to the granted channel only
- Grant_ch  out  log2(NCH) (min 1)  granted channel index
- Grant_dir  out  1  1 = write, 0 = read
- Busy  out  1  state ≠ IDLE

## Operation
- Slot request, for channel i:
  - wr_req[i] = Ch_en[i] & ~Ch_load[i] & (wr_level ≥ BL)
  - rd_req[i] = Ch_en[i] & ~Ch_load[i] & (rd_level < RD_THRESH)
- Slot order: wr0, rd0, wr1, rd1, … Round-robin search starts at the slot after the last granted one. After reset, the search starts at wr0.
- FSM IDLE → ISSUE → XFER → IDLE:
  - IDLE: if any slot requests, register the winner into Grant_ch/Grant_dir, latch its pointer onto Sd_*addr, set Sd_wr or Sd_rd, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: hold the command and address stable until Sd_ack=1. On that edge, clear Sd_wr/Sd_rd and go to XFER.
  - XFER: Ch_wr_vaild[Grant_ch] = Sd_wdata_vaild when Grant_dir=1, else Ch_rd_vaild[Grant_ch] = Sd_rdata_vaild. This is combinational; all other bits are 0. On the done pulse matching Grant_dir, advance the pointer and go to IDLE. A done pulse of the other direction is ignored.
- Pointer advance (computed in AW+1 bits): if ptr+BL ≥ max, then ptr ← base; else ptr ← ptr+BL.
- Address split: caddr = ptr[CW-1:0], raddr = ptr[CW+RW-1:CW], baddr = ptr[AW-1:CW+RW].
- Ch_load[i]:
  - Reloads both of channel i's pointers to base every cycle it is high.
  - If it coincides with the done pulse for channel i, the load wins and there is no advance.
  - A burst already in flight completes normally.
- Data-valid strobes outside XFER are not forwarded.

## Timing
- Reset values: state IDLE; Sd_wr=Sd_rd=0; Sd_*addr=0; Grant_ch=0; Grant_dir=0; Busy=0; Ch_*_vaild=0; all pointers = their base; RR pointer at wr0.
- Request latency: a request true at edge n gives Sd_wr/Sd_rd=1 after edge n (1 cycle).
- Ack handling: if Sd_ack=1 at edge k, the command is low after k.
- Turnaround: after done at edge d, IDLE in cycle d+1, so the next command is visible after edge d+1 (minimum 1 idle cycle between bursts).
- Rst mid-burst: return to reset values on the next edge; in-flight strobes are dropped.

## Test plan
- Single channel write: NCH=1, wr_level=8, base 0, max 32. Four bursts issue with caddr 0, 8, 16, 24, then wrap to 0 on the 5th.
- Round-robin: all 8 slots requesting continuously. Grant sequence is wr0, rd0, wr1, rd1, wr2, rd2, wr3, rd3, wr0; no slot is starved.
- Address split: wr base 0x400A08 → Sd_baddr=1, Sd_raddr=5, Sd_caddr=8.
- Ack stall: hold Sd_ack=0 for 10 cycles. Sd_wr and the address stay constant for 10 cycles; Busy=1 throughout.
- Load collision: Ch_load[2] pulses in the same cycle as Sd_wdata_done for a ch2 write. The pointer equals base afterwards, not base+8.
- Strobe routing: ch1 read granted, Sd_rdata_vaild high for 8 cycles. Only Ch_rd_vaild[1] toggles; Rst during the burst clears everything next cycle.
